// File: rtl/oled_spi_sink.sv
// rtl/oled_spi_sink.sv - OLED SPI receive model with 1024-byte frame buffer and read port
module oled_spi_sink #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       sclk_i,
  input  logic       sdin_i,
  input  logic       cs_i,
  input  logic       dc_i,
  input  logic       oled_reset_i,
  input  logic [9:0] rd_addr_i,
  output logic [7:0] rd_data_o,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       byte_dc_o,
  output logic [9:0] wr_ptr_o,
  output logic       frame_done_o
);

  localparam logic [1:0] ST_HOLD  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  // Pin bundle order {sclk, sdin, cs, dc, oled_reset}; idle levels used on reset.
  localparam logic [4:0] PIN_IDLE = 5'b00101;

  logic [4:0] w_pins_raw;
  logic [4:0] w_pins;
  logic       w_sclk;
  logic       w_sdin;
  logic       w_cs;
  logic       w_dc;
  logic       w_rstn;

  assign w_pins_raw = {sclk_i, sdin_i, cs_i, dc_i, oled_reset_i};

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_pins = w_pins_raw;
    end else begin : g_sync
      logic [4:0] r_sync [SYNC_STAGES];
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= PIN_IDLE;
        end else begin
          r_sync[0] <= w_pins_raw;
          for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
      end
      assign w_pins = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  assign {w_sclk, w_sdin, w_cs, w_dc, w_rstn} = w_pins;

  // Decode stage: edge detect plus aligned copies of the other pins.
  logic       r_sclk_prev;
  logic       r_rise;
  logic       r_sdin_q;
  logic       r_cs_q;
  logic       r_dc_q;
  logic       r_rstn_q;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_byte_done;
  logic       w_ram_we;

  always_comb begin
    w_state_nxt = ST_IDLE;
    if (!r_rstn_q) begin
      w_state_nxt = ST_HOLD;
    end else if (!r_cs_q) begin
      w_state_nxt = ST_SHIFT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_sclk_prev  <= 1'b0;
      r_rise       <= 1'b0;
      r_sdin_q     <= 1'b0;
      r_cs_q       <= 1'b1;
      r_dc_q       <= 1'b0;
      r_rstn_q     <= 1'b1;
      r_state      <= ST_IDLE;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'h00;
      r_byte_done  <= 1'b0;
      byte_o       <= 8'h00;
      byte_dc_o    <= 1'b0;
      byte_valid_o <= 1'b0;
      frame_done_o <= 1'b0;
      wr_ptr_o     <= 10'd0;
    end else begin
      r_sclk_prev  <= w_sclk;
      r_rise       <= w_sclk & ~r_sclk_prev;
      r_sdin_q     <= w_sdin;
      r_cs_q       <= w_cs;
      r_dc_q       <= w_dc;
      r_rstn_q     <= w_rstn;
      r_state      <= w_state_nxt;
      r_byte_done  <= 1'b0;
      byte_valid_o <= 1'b0;
      frame_done_o <= 1'b0;

      // A CS rise or panel reset in the same cycle as an SCLK rise drops the bit.
      if (w_state_nxt == ST_SHIFT && r_rise) begin
        r_shift   <= {r_shift[6:0], r_sdin_q};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          byte_o      <= {r_shift[6:0], r_sdin_q};
          byte_dc_o   <= r_dc_q;
          r_byte_done <= 1'b1;
        end
      end else if (r_state == ST_SHIFT && w_state_nxt != ST_SHIFT) begin
        r_bit_cnt <= 3'd0;
        r_shift   <= 8'h00;
      end

      if (r_byte_done) begin
        byte_valid_o <= 1'b1;
        if (byte_dc_o) begin
          wr_ptr_o     <= wr_ptr_o + 10'd1;
          frame_done_o <= (wr_ptr_o == 10'd1023);
        end
      end else if (w_state_nxt == ST_HOLD) begin
        wr_ptr_o <= 10'd0;
      end
    end
  end

  // Frame buffer: no reset, read-before-write on address collision.
  logic [7:0] r_ram [1024];

  assign w_ram_we = r_byte_done & byte_dc_o & ~reset_i;

  always_ff @(posedge clk_i) begin
    if (w_ram_we) begin
      r_ram[wr_ptr_o] <= byte_o;
    end
    rd_data_o <= r_ram[rd_addr_i];
  end

endmodule

// File: doc/oled_spi_sink.md
# oled_spi_sink

Receive-side model of the OLED SPI link: samples SCLK/SDIN/CS/DC/RESET as driven by the screen driver, decodes them into command and data bytes, and stores data bytes in a 1024-byte frame buffer (128x64, one byte = 8 vertical pixels of one page column). A random-access read port lets a checker or a mirror display read the captured frame back, using the same address/data convention as the text engine's pixel port. It closes the loop for on-board self-test and for simulation of the display path.

## Interface
- SYNC_STAGES, 2, flops on each pin input before use. Legal values are 0..3; 0 means the pins are taken directly.
- clk_i  input  1  system clock
- reset_i  input  1  synchronous, active-high reset
- sclk_i  input  1  SPI clock; data is sampled on the rising edge
- sdin_i  input  1  SPI data, MSB first
- cs_i  input  1  chip select, active low
- dc_i  input  1  0 = command byte, 1 = data byte
- oled_reset_i  input  1  panel reset, active low
- rd_addr_i  input  10  frame buffer read address
- rd_data_o  output  8  frame buffer read data
- byte_valid_o  output  1  one-cycle pulse: a byte has been received
- byte_o  output  8  received byte, held until the next byte
- byte_dc_o  output  1  DC value captured with byte_o
- wr_ptr_o  output  10  next frame buffer write address
- frame_done_o  output  1  one-cycle pulse when wr_ptr wraps from 1023 to 0

## Operation
- **Synchronizer.** Each pin passes through SYNC_STAGES flops. `sclk_rise` = synced SCLK is 1 and was 0 in the previous cycle.
- **States.**
  - HOLD: entered while synced oled_reset is 0.
  - IDLE: synced CS is 1.
  - SHIFT: synced CS is 0.
- **Transitions.**
  - HOLD has priority over everything.
  - IDLE→SHIFT on CS falling. SHIFT→IDLE on CS rising.
  - HOLD→IDLE or HOLD→SHIFT on oled_reset release, chosen by the CS level.
- **SHIFT behaviour.** On each `sclk_rise`: shift_reg <= {shift_reg[6:0], sdin}, bit_cnt (3 bits) increments.
- **Byte completion.** On the rise where bit_cnt is 7:
  - byte_o <= the completed byte; byte_dc_o <= synced DC as sampled on that edge.
  - byte_valid_o pulses in the next cycle; bit_cnt wraps to 0.
- **Data byte write.** If DC = 1, the byte is written to ram[wr_ptr] on the same edge that raises byte_valid_o, then wr_ptr increments modulo 1024.
  - On 1023→0, frame_done_o pulses in the same cycle as byte_valid_o.
- **Command byte.** If DC = 0, only byte_o, byte_dc_o and byte_valid_o update. No RAM write, wr_ptr unchanged.
- **CS rising mid-byte.** Partial bits are discarded and bit_cnt <= 0. No pulse, no write.
- **HOLD.** Same as CS rising, plus wr_ptr <= 0. The RAM is not cleared.
- **reset_i.**
  - State <= IDLE; bit_cnt, shift_reg, wr_ptr <= 0.
  - byte_o <= 0x00; byte_dc_o, byte_valid_o, frame_done_o <= 0.
  - Synchronizer flops <= idle pin levels: SCLK 0, CS 1, oled_reset 1, others 0.
  - RAM contents are undefined after power-up and untouched by reset.
  - reset_i mid-byte aborts the byte with no pulse.
- **Read port.**
  - Synchronous read: rd_data_o is registered from ram[rd_addr_i].
  - A same-cycle read and write at the same address returns the old data (read-before-write).
  - Reset does not affect rd_data_o.

## Timing
- **Pin to pulse latency.** From the first clk_i edge that samples sclk_i high on the 8th bit to byte_valid_o high: SYNC_STAGES + 2 cycles.
- **Input rate limits.**
  - SCLK high and low phases must each be ≥ SYNC_STAGES + 1 clk_i cycles.
  - SDIN and DC must be stable for ≥ SYNC_STAGES + 1 cycles around each SCLK rise.
  - With SYNC_STAGES = 0, a 1-cycle minimum phase is allowed.
- **Pulse widths.** byte_valid_o and frame_done_o are exactly 1 cycle. Minimum spacing between byte_valid_o pulses is 8 SCLK periods.
- **Read latency.** rd_data_o reflects rd_addr_i 1 cycle after it is presented.
- **RAM update visibility.** A written byte is readable via rd_addr_i = old wr_ptr from the cycle after byte_valid_o.
- **CS edge racing an SCLK rise.** If CS rises in the same synced cycle as a `sclk_rise`, CS wins and the bit is dropped.

## Test plan
- **Reset values.** Assert reset_i for 3 cycles → byte_o = 0x00, byte_valid_o = 0, frame_done_o = 0, wr_ptr_o = 0.
- **Command byte.** CS low, DC = 0, shift 0xAF, CS high:
  - byte_valid_o pulses once, with byte_o = 0xAF and byte_dc_o = 0;
  - wr_ptr_o stays 0.
- **Data bytes.** DC = 1, shift 0x3C then 0xC3:
  - two pulses; wr_ptr_o = 2;
  - reading address 0 returns 0x3C and address 1 returns 0xC3, one cycle after each address is presented.
- **Full frame and wrap.** Stream 1024 data bytes, value = address[7:0] ^ 0x5A:
  - frame_done_o pulses exactly once, on byte 1024; wr_ptr_o = 0;
  - every address reads back its value;
  - byte 1025 (0x11) overwrites address 0.
- **Abort.** CS high after 5 bits, then a full 0x81:
  - exactly one pulse, byte_o = 0x81;
  - no stray RAM write.
- **Panel reset.** After 10 data bytes, drive oled_reset_i low for 4 cycles, release, send 0x77 with DC = 1:
  - 0x77 is written to address 0; wr_ptr_o = 1;
  - the old address 1 contents are unchanged.
